mem_arbiter: RTL

- Shares one single-port memory (gnr_ram-style, with variable-latency `ready`) between the instruction-fetch requester and the load/store requester.
- Sits between the fetch/ctrl_flow front end, the LSU and the unified memory.
- Fixed priority to load/store, with a bounded-starvation guarantee for fetch.
- Supports fetch flush on taken branch/jump.
- Produces the fetch stall used as ctrl_flow `pause`.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_starve_counter.sv | 44 ++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory arbiter: parameter defaults and FSM state encoding.
package mem_pkg;

   localparam int DEF_XLEN     = 32;
   localparam int DEF_MAX_WAIT = 4;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE    = 2'd0;
   localparam arb_state_t ARB_BUSY_IF = 2'd1;
   localparam arb_state_t ARB_BUSY_LS = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
);
   // fetch requester
   logic            if_req;
   logic [XLEN-1:0] if_addr;
   logic            if_flush;
   logic            if_valid;
   logic [XLEN-1:0] if_rdata;
   logic            fetch_stall;
   // load/store requester
   logic            ls_req;
   logic            ls_we;
   logic [XLEN-1:0] ls_addr;
   logic [XLEN-1:0] ls_wdata;
   logic            ls_valid;
   logic [XLEN-1:0] ls_rdata;
   // unified memory
   logic            mem_en;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ready;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      output if_valid, if_rdata, fetch_stall,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      output ls_valid, ls_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      input  if_valid, if_rdata, fetch_stall,
      output ls_req, ls_we, ls_addr, ls_wdata,
      input  ls_valid, ls_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive arbitration losses suffered by fetch.
// sat tells the arbiter that fetch must win the next arbitration.
module starve_counter
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int CW       = $clog2(MAX_WAIT + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over increment; increment stops at MAX_CNT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (inc && (cnt_q < MAX_CNT)) begin
         cnt_d = cnt_q + CW'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q >= MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency single-port memory between instruction
// fetch and load/store. Load/store has priority, fetch is forced through after
// MAX_WAIT consecutive losses, and a flushed fetch completes silently.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   arb_state_t state_q, state_d;

   logic            mem_en_q,    mem_en_d;
   logic            mem_we_q,    mem_we_d;
   logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic            if_valid_q,  if_valid_d;
   logic [XLEN-1:0] if_rdata_q,  if_rdata_d;
   logic            ls_valid_q,  ls_valid_d;
   logic [XLEN-1:0] ls_rdata_q,  ls_rdata_d;
   logic            drop_q,      drop_d;

   logic starve_sat_s;
   logic ls_win_s;
   logic if_win_s;
   logic starve_inc_s;

   // Arbitration decision, only meaningful while idle.
   assign ls_win_s     = (state_q == ARB_IDLE) && bus.ls_req &&
                         (!bus.if_req || !starve_sat_s);
   assign if_win_s     = (state_q == ARB_IDLE) && !ls_win_s &&
                         bus.if_req && !bus.if_flush;
   assign starve_inc_s = ls_win_s && bus.if_req && !bus.if_flush;

   starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clock (clock),
      .reset (reset),
      .inc   (starve_inc_s),
      .clr   (if_win_s),
      .sat   (starve_sat_s)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant from idle, return to idle on memory completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (ls_win_s) begin
               state_d = ARB_BUSY_LS;
            end else if (if_win_s) begin
               state_d = ARB_BUSY_IF;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY_IF, ARB_BUSY_LS: begin
            if (bus.mem_ready) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Output/datapath next values: launch access on grant, capture on completion.
   always_comb begin
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_valid_d  = 1'b0;
      ls_rdata_d  = ls_rdata_q;
      drop_d      = drop_q;
      case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            if (ls_win_s) begin
               mem_en_d    = 1'b1;
               mem_we_d    = bus.ls_we;
               mem_addr_d  = bus.ls_addr;
               mem_wdata_d = bus.ls_wdata;
            end else if (if_win_s) begin
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = {XLEN{1'b0}};
            end else begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
            end
         end
         ARB_BUSY_IF: begin
            if (bus.mem_ready) begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               drop_d   = 1'b0;
               // A flush seen during the access or on this edge discards the result.
               if (!(drop_q || bus.if_flush)) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end else begin
                  if_valid_d = 1'b0;
                  if_rdata_d = if_rdata_q;
               end
            end else begin
               drop_d = drop_q | bus.if_flush;
            end
         end
         ARB_BUSY_LS: begin
            if (bus.mem_ready) begin
               mem_en_d   = 1'b0;
               mem_we_d   = 1'b0;
               ls_valid_d = 1'b1;
               // Stores leave the load data register untouched.
               if (!mem_we_q) begin
                  ls_rdata_d = bus.mem_rdata;
               end else begin
                  ls_rdata_d = ls_rdata_q;
               end
            end else begin
               ls_valid_d = 1'b0;
            end
         end
         default: begin
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            drop_d   = 1'b0;
         end
      endcase
   end

   // Output and capture registers, all cleared by the asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {XLEN{1'b0}};
         mem_wdata_q <= {XLEN{1'b0}};
         if_valid_q  <= 1'b0;
         if_rdata_q  <= {XLEN{1'b0}};
         ls_valid_q  <= 1'b0;
         ls_rdata_q  <= {XLEN{1'b0}};
         drop_q      <= 1'b0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_valid_q  <= if_valid_d;
         if_rdata_q  <= if_rdata_d;
         ls_valid_q  <= ls_valid_d;
         ls_rdata_q  <= ls_rdata_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.mem_en      = mem_en_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.ls_valid    = ls_valid_q;
   assign bus.ls_rdata    = ls_rdata_q;
   assign bus.fetch_stall = bus.if_req & ~if_valid_q;

endmodule
